// File: rtl/pulse_generator.sv
// Programmable pulse/PWM generator with burst count, on the 16-bit IO bus.
// Emits a registered waveform, a one-cycle period tick and a done strobe.
module pulse_generator (
    input  logic        clock,
    input  logic        reset,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [2:0]  address,
    input  logic [15:0] write_data_in,
    output logic [15:0] read_data_out,
    output logic        pwm_out,
    output logic        period_tick,
    output logic        done_n
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_next;
    logic        enable, enable_next;
    logic        invert, invert_next;
    logic        done, done_next;
    logic [15:0] period_sh, period_sh_next;
    logic [15:0] compare_sh, compare_sh_next;
    logic [15:0] period_act, period_act_next;
    logic [15:0] compare_act, compare_act_next;
    logic [15:0] remain, remain_next;
    logic [15:0] cnt, cnt_next;
    logic [15:0] read_next;
    logic        pwm_next, tick_next, pulse_next;

    logic wr, ctrl_wr, period_wr, compare_wr, burst_wr, status_rd;
    logic wrap, last_wrap, running;

    assign running    = (state == RUN);
    assign wr         = write_enable & ~read_enable;
    assign ctrl_wr    = wr && (address == 3'b000);
    assign period_wr  = wr && (address == 3'b010);
    assign compare_wr = wr && (address == 3'b100);
    assign burst_wr   = wr && (address == 3'b110);
    assign status_rd  = read_enable && (address == 3'b000);

    assign wrap      = running && (cnt == period_act);
    // A coincident BURST or CTRL write overrides burst completion
    assign last_wrap = wrap && (remain == 16'd1) && !burst_wr && !ctrl_wr;

    always_comb begin
        state_next       = state;
        enable_next      = enable;
        invert_next      = invert;
        done_next        = done;
        period_sh_next   = period_sh;
        compare_sh_next  = compare_sh;
        period_act_next  = period_act;
        compare_act_next = compare_act;
        remain_next      = remain;
        cnt_next         = cnt;

        if (wrap) begin
            cnt_next         = 16'd0;
            period_act_next  = period_sh;
            compare_act_next = compare_sh;
            if (remain != 16'd0)
                remain_next = remain - 16'd1;
        end else if (running) begin
            cnt_next = cnt + 16'd1;
        end

        if (last_wrap) begin
            state_next  = IDLE;
            enable_next = 1'b0;
        end

        if (period_wr)
            period_sh_next = write_data_in;
        if (compare_wr)
            compare_sh_next = write_data_in;
        if (burst_wr)
            remain_next = write_data_in;

        if (ctrl_wr) begin
            invert_next = write_data_in[1];
            enable_next = write_data_in[0];
            cnt_next    = 16'd0;
            if (write_data_in[0]) begin
                state_next       = RUN;
                period_act_next  = period_sh;
                compare_act_next = compare_sh;
            end else begin
                state_next = IDLE;
            end
        end

        // Completion wins over a simultaneous STATUS read clear
        if (status_rd)
            done_next = 1'b0;
        if (last_wrap)
            done_next = 1'b1;
    end

    always_comb begin
        read_next = 16'h0000;
        unique case (address)
            3'b000:  read_next = {running, 12'd0, invert, done, enable};
            3'b010:  read_next = period_sh;
            3'b100:  read_next = compare_sh;
            3'b110:  read_next = remain;
            default: read_next = 16'h0000;
        endcase
    end

    always_comb begin
        if (state_next == RUN)
            pwm_next = (cnt_next < compare_act_next) ^ invert_next;
        else
            pwm_next = invert_next;
        tick_next  = wrap && !ctrl_wr;
        pulse_next = last_wrap;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            enable        <= 1'b0;
            invert        <= 1'b0;
            done          <= 1'b0;
            period_sh     <= 16'hFFFF;
            compare_sh    <= 16'h8000;
            period_act    <= 16'hFFFF;
            compare_act   <= 16'h8000;
            remain        <= 16'd0;
            cnt           <= 16'd0;
            read_data_out <= 16'h0000;
            pwm_out       <= 1'b0;
            period_tick   <= 1'b0;
            done_n        <= 1'b1;
        end else begin
            state       <= state_next;
            enable      <= enable_next;
            invert      <= invert_next;
            done        <= done_next;
            period_sh   <= period_sh_next;
            compare_sh  <= compare_sh_next;
            period_act  <= period_act_next;
            compare_act <= compare_act_next;
            remain      <= remain_next;
            cnt         <= cnt_next;
            if (read_enable)
                read_data_out <= read_next;
            pwm_out     <= pwm_next;
            period_tick <= tick_next;
            done_n      <= ~pulse_next;
        end
    end
endmodule

// File: tb/tb_pulse_generator.sv
// Scoreboard bench for pulse_generator: expected waveform and read data
// are queued when stimulus is applied and popped as the DUT responds.
module tb_pulse_generator;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        read_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [2:0]  address = 3'b000;
    logic [15:0] write_data_in = 16'h0000;
    logic [15:0] read_data_out;
    logic        pwm_out;
    logic        period_tick;
    logic        done_n;

    int total = 0;
    int bad = 0;

    logic [2:0]  wq[$];
    logic [15:0] rq[$];

    pulse_generator dut (
        .clock(clock),
        .reset(reset),
        .read_enable(read_enable),
        .write_enable(write_enable),
        .address(address),
        .write_data_in(write_data_in),
        .read_data_out(read_data_out),
        .pwm_out(pwm_out),
        .period_tick(period_tick),
        .done_n(done_n)
    );

    always #5 clock = ~clock;

    // Bus tasks start and end on a falling edge
    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        address = a;
        write_data_in = d;
        write_enable = 1'b1;
        @(negedge clock);
        write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        address = a;
        read_enable = 1'b1;
        @(negedge clock);
        read_enable = 1'b0;
        d = read_data_out;
    endtask

    task automatic test_reset();
        logic [2:0]  addrs[4];
        logic [15:0] rd, e;
        addrs = '{3'b000, 3'b010, 3'b100, 3'b110};
        total++;
        if ({pwm_out, period_tick, done_n} !== 3'b001) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=001", {pwm_out, period_tick, done_n});
        end
        total++;
        if (read_data_out !== 16'h0000) begin
            bad++;
            $display("FAIL reset_rdata got=%h exp=0000", read_data_out);
        end
        rq.push_back(16'h0000);
        rq.push_back(16'hFFFF);
        rq.push_back(16'h8000);
        rq.push_back(16'h0000);
        for (int i = 0; i < 4; i++) begin
            bus_read(addrs[i], rd);
            e = rq.pop_front();
            total++;
            if (rd !== e) begin
                bad++;
                $display("FAIL reset_read a=%0d got=%h exp=%h", addrs[i], rd, e);
            end
        end
    endtask

    task automatic test_continuous();
        logic [2:0] e;
        bus_write(3'b010, 16'd4);
        bus_write(3'b100, 16'd2);
        bus_write(3'b110, 16'd0);
        for (int i = 0; i < 15; i++)
            wq.push_back({(i % 5) < 2, (i > 0) && (i % 5 == 0), 1'b1});
        bus_write(3'b000, 16'h0001);
        for (int i = 0; i < 15; i++) begin
            e = wq.pop_front();
            total++;
            if ({pwm_out, period_tick, done_n} !== e) begin
                bad++;
                $display("FAIL continuous cyc=%0d got=%b exp=%b", i, {pwm_out, period_tick, done_n}, e);
            end
            @(negedge clock);
        end
        bus_write(3'b000, 16'h0000);
    endtask

    task automatic test_burst();
        logic [2:0]  e;
        logic [15:0] rd, re;
        int          pulses;
        logic        prev;
        pulses = 0;
        prev = 1'b0;
        bus_write(3'b010, 16'd3);
        bus_write(3'b100, 16'd1);
        bus_write(3'b110, 16'd3);
        for (int i = 0; i < 16; i++)
            wq.push_back({(i < 12) && (i % 4 == 0),
                          (i > 0) && (i % 4 == 0) && (i <= 12), i != 12});
        bus_write(3'b000, 16'h0001);
        for (int i = 0; i < 16; i++) begin
            e = wq.pop_front();
            total++;
            if ({pwm_out, period_tick, done_n} !== e) begin
                bad++;
                $display("FAIL burst cyc=%0d got=%b exp=%b", i, {pwm_out, period_tick, done_n}, e);
            end
            if (pwm_out && !prev)
                pulses++;
            prev = pwm_out;
            @(negedge clock);
        end
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL burst_pulses got=%0d exp=3", pulses);
        end
        rq.push_back(16'h0002);
        rq.push_back(16'h0000);
        rq.push_back(16'h0000);
        for (int i = 0; i < 3; i++) begin
            bus_read((i == 2) ? 3'b110 : 3'b000, rd);
            re = rq.pop_front();
            total++;
            if (rd !== re) begin
                bad++;
                $display("FAIL burst_status n=%0d got=%h exp=%h", i, rd, re);
            end
        end
    endtask

    task automatic test_shadow();
        logic [2:0] e;
        bus_write(3'b010, 16'd9);
        bus_write(3'b100, 16'd5);
        bus_write(3'b110, 16'd0);
        for (int i = 0; i < 20; i++)
            wq.push_back({(i < 10) ? (i < 5) : ((i - 10) < 2), i == 10, 1'b1});
        bus_write(3'b000, 16'h0001);
        for (int i = 0; i < 20; i++) begin
            e = wq.pop_front();
            total++;
            if ({pwm_out, period_tick, done_n} !== e) begin
                bad++;
                $display("FAIL shadow cyc=%0d got=%b exp=%b", i, {pwm_out, period_tick, done_n}, e);
            end
            if (i == 1)
                bus_write(3'b100, 16'd2);
            else
                @(negedge clock);
        end
        bus_write(3'b000, 16'h0000);
    endtask

    task automatic test_corners();
        logic [15:0] cmps[2];
        logic [15:0] ctrls[2];
        logic [2:0]  e;
        cmps = '{16'h0000, 16'hFFFF};
        ctrls = '{16'h0001, 16'h0003};
        bus_write(3'b010, 16'd7);
        for (int c = 0; c < 2; c++) begin
            bus_write(3'b100, cmps[c]);
            for (int v = 0; v < 2; v++) begin
                for (int i = 0; i < 10; i++)
                    wq.push_back({(c == 1) ^ (v == 1), i == 8, 1'b1});
                bus_write(3'b000, ctrls[v]);
                for (int i = 0; i < 10; i++) begin
                    e = wq.pop_front();
                    total++;
                    if ({pwm_out, period_tick, done_n} !== e) begin
                        bad++;
                        $display("FAIL corner c=%0d inv=%0d cyc=%0d got=%b exp=%b",
                                 c, v, i, {pwm_out, period_tick, done_n}, e);
                    end
                    @(negedge clock);
                end
            end
        end
        bus_write(3'b000, 16'h0000);
    endtask

    task automatic test_disable();
        logic [2:0]  e;
        logic [15:0] rd, re;
        logic [15:0] on[2];
        logic [15:0] off[2];
        on = '{16'h0001, 16'h0003};
        off = '{16'h0000, 16'h0002};
        bus_write(3'b010, 16'd9);
        bus_write(3'b100, 16'd5);
        for (int v = 0; v < 2; v++) begin
            wq.push_back({v == 0, 2'b01});
            wq.push_back({v == 0, 2'b01});
            wq.push_back({v == 1, 2'b01});
            bus_write(3'b000, on[v]);
            for (int i = 0; i < 3; i++) begin
                e = wq.pop_front();
                total++;
                if ({pwm_out, period_tick, done_n} !== e) begin
                    bad++;
                    $display("FAIL disable inv=%0d cyc=%0d got=%b exp=%b", v, i, {pwm_out, period_tick, done_n}, e);
                end
                if (i == 1)
                    bus_write(3'b000, off[v]);
                else if (i == 0)
                    @(negedge clock);
            end
        end
        rq.push_back(16'h0004);
        bus_read(3'b000, rd);
        re = rq.pop_front();
        total++;
        if (rd !== re) begin
            bad++;
            $display("FAIL disable_status got=%h exp=%h", rd, re);
        end
        bus_write(3'b000, 16'h0000);
    endtask

    task automatic test_collision();
        logic [15:0] rd, re;
        rq.push_back(16'd9);
        rq.push_back(16'd9);
        address = 3'b010;
        write_data_in = 16'h0005;
        read_enable = 1'b1;
        write_enable = 1'b1;
        @(negedge clock);
        read_enable = 1'b0;
        write_enable = 1'b0;
        re = rq.pop_front();
        total++;
        if (read_data_out !== re) begin
            bad++;
            $display("FAIL collision_read got=%h exp=%h", read_data_out, re);
        end
        bus_read(3'b010, rd);
        re = rq.pop_front();
        total++;
        if (rd !== re) begin
            bad++;
            $display("FAIL collision_period got=%h exp=%h", rd, re);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [2:0]  e;
        logic [15:0] rd, re;
        logic [2:0]  addrs[4];
        addrs = '{3'b000, 3'b010, 3'b100, 3'b110};
        bus_write(3'b010, 16'd3);
        bus_write(3'b100, 16'd1);
        bus_write(3'b110, 16'd3);
        bus_write(3'b000, 16'h0001);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        total++;
        if (read_data_out !== 16'h0000) begin
            bad++;
            $display("FAIL midreset_rdata got=%h exp=0000", read_data_out);
        end
        for (int i = 0; i < 16; i++)
            wq.push_back(3'b001);
        for (int i = 0; i < 16; i++) begin
            e = wq.pop_front();
            total++;
            if ({pwm_out, period_tick, done_n} !== e) begin
                bad++;
                $display("FAIL midreset cyc=%0d got=%b exp=%b", i, {pwm_out, period_tick, done_n}, e);
            end
            @(negedge clock);
        end
        rq.push_back(16'h0000);
        rq.push_back(16'hFFFF);
        rq.push_back(16'h8000);
        rq.push_back(16'h0000);
        for (int i = 0; i < 4; i++) begin
            bus_read(addrs[i], rd);
            re = rq.pop_front();
            total++;
            if (rd !== re) begin
                bad++;
                $display("FAIL midreset_read a=%0d got=%h exp=%h", addrs[i], rd, re);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_continuous();
        test_burst();
        test_shadow();
        test_corners();
        test_disable();
        test_collision();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pulse_generator.md
# pulse_generator

Memory-mapped programmable pulse/PWM generator on the IO bus, the sending counterpart of the timer/counter's external pulse-counting inputs. Software programs period, high time, polarity and an optional burst length. The block then drives a registered waveform plus a one-cycle period tick that can be wired straight into a counter channel's pulse input. It uses the same 16-bit halfword register access and enable-strobe bus style as the other IO peripherals.

## Interface
- No parameters; all widths fixed at 16 bits.
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- read_enable  in  1  register read strobe, one cycle
- write_enable  in  1  register write strobe, one cycle
- address  in  3  halfword select: 000 CTRL/STATUS, 010 PERIOD, 100 COMPARE, 110 BURST/REMAIN
- write_data_in  in  16  write data
- read_data_out  out  16  registered read data
- pwm_out  out  1  generated waveform, registered
- period_tick  out  1  one-cycle high pulse at each period wrap
- done_n  out  1  active-low, one-cycle pulse when a burst completes

## Operation
- **Register map**
  - CTRL (write 000):
    - bit0 enable
    - bit1 invert
    - other bits ignored
  - STATUS (read 000):
    - bit15 running
    - bit2 invert
    - bit1 done (sticky)
    - bit0 enable
    - Reading STATUS clears done.
  - PERIOD (010, R/W): shadow value.
    - Period length is PERIOD+1 cycles.
    - Reset value 16'hFFFF.
  - COMPARE (100, R/W): shadow high time in cycles. Reset value 16'h8000.
  - BURST (110 write): number of periods to emit; 0 = continuous.
    - Loads the remain counter immediately.
    - Also accepted while running.
  - REMAIN (110 read): periods still to emit.
- **Bus rules**
  - Read has priority: if read_enable and write_enable are both high, the write is dropped.
  - Reads of PERIOD/COMPARE return the shadow values.
  - Unused addresses (odd values) read 16'h0000; writes to them are ignored.
- **Counter**
  - cnt (16-bit) counts 0..per_act.
  - When cnt == per_act at an edge, cnt becomes 0 (wrap).
  - Active registers per_act and cmp_act load from the shadows on enable and at every wrap. Shadow writes never change the current period.
- **Waveform**
  - raw = (cnt < cmp_act).
  - pwm_out = raw XOR invert while running.
  - pwm_out = invert while idle.
  - COMPARE = 0 gives a constant inactive level.
  - COMPARE > PERIOD gives a constant active level.
- **States**
  - IDLE:
    - cnt = 0.
    - Entered on reset, on a CTRL write with enable=0, or on burst completion.
  - RUN:
    - Entered on a CTRL write with enable=1 from IDLE.
    - On entry: cnt := 0, active registers loaded.
    - Writing enable=1 while already in RUN restarts the current period (cnt := 0, active registers reloaded). REMAIN is unchanged.
- **Burst**
  - At each wrap with remain ≠ 0: remain decrements.
  - At a wrap where remain goes 1→0:
    - The block enters IDLE and clears the enable bit.
    - done is set.
    - done_n pulses low.
    - period_tick still pulses.
  - With remain = 0 at enable, the block runs continuously.
- **Invert** can be written at any time and takes effect on pwm_out from the next cycle.

## Timing
- **Reset values**
  - read_data_out = 0, pwm_out = 0, period_tick = 0, done_n = 1.
  - CTRL = 0, remain = 0, done = 0, cnt = 0.
  - PERIOD = 16'hFFFF, COMPARE = 16'h8000, both for shadow and active.
  - Reset mid-burst aborts immediately; there is no done_n pulse.
- **Read latency**
  - read_data_out is valid on the cycle after the read_enable edge.
  - It holds its value until the next read.
- **pwm_out, period_tick, done_n** are registered from the post-edge state, so they are aligned with the cnt value they describe.
  - After the edge that enables, pwm_out = (COMPARE>0) XOR invert in that same cycle.
  - period_tick is high during the cycle where cnt = 0 following a wrap. It is not high on the initial enable.
  - done_n is low in the cycle after the final wrap; pwm_out is idle in that same cycle.
- **Write timing**
  - A BURST write at the same edge as a wrap: the written value wins and no decrement happens.
  - A CTRL enable=0 write at the same edge as the final wrap: the block goes idle with no done pulse.
- A PERIOD write that makes per_act smaller than the current cnt cannot occur, because per_act changes only at a wrap.

## Test plan
- **Reset values:** Reset, then read all four addresses → STATUS 0x0000, PERIOD 0xFFFF, COMPARE 0x8000, REMAIN 0x0000. Check pwm_out=0 and done_n=1.
- **Continuous run:** PERIOD=4, COMPARE=2, BURST=0, CTRL=0x0001.
  - pwm_out pattern is 1,1,0,0,0 repeating.
  - period_tick is high every 5th cycle, first at cycle 5 after enable.
- **Burst:** PERIOD=3, COMPARE=1, BURST=3, enable.
  - Exactly 3 high pulses.
  - done_n is low for 1 cycle at cycle 12.
  - STATUS reads 0x0002, then 0x0000. REMAIN reads 0.
- **Shadow load:** During a PERIOD=9/COMPARE=5 run, write COMPARE=2 at cnt=1.
  - The current period keeps 5 high cycles.
  - The next period has 2 high cycles.
- **Corner cases:**
  - COMPARE=0 → pwm_out constant 0.
  - COMPARE=0xFFFF with PERIOD=7 → constant 1.
  - Setting invert=1 flips both results.
  - Disable mid-period → pwm_out returns to invert level on the next cycle.
- **Collisions:**
  - read_enable+write_enable together on 010 with data 0x0005 → PERIOD is unchanged.
  - Reset asserted mid-burst → all outputs return to reset values, with no done_n pulse.
